pipe_ctrl: RTL

Pipeline sequencer for the five-stage core. It drives the freeze, bubble and flush inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB stage registers. It resolves three sources of disturbance: RAW data hazards, taken branches, and multi-cycle data-memory accesses. A wait-state FSM holds the whole pipeline during memory accesses, and saturating counters record stall, freeze and flush activity.

---
 rtl/cpu_ctrl_pkg.sv | 34 +++
 rtl/pipe_ctrl_hazard_detect.sv | 36 +++
 rtl/pipe_ctrl.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared types and constants for the pipeline sequencer.
package cpu_ctrl_pkg;

  localparam int unsigned REG_ADDR_W = 4;
  localparam int unsigned WCNT_W     = 4;
  localparam int unsigned CNT_W_DEF  = 16;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_WAIT = 1'b1
  } state_e;

  // Control bundle driven onto the stage registers.
  typedef struct packed {
    logic freeze_pc;
    logic freeze_if_id;
    logic freeze_id_ex;
    logic freeze_ex_mem;
    logic freeze_mem_wb;
    logic bubble_id_ex;
    logic flush_if_id;
  } pipe_ctl_t;

  // True when either live source operand of the ID instruction names rd.
  function automatic logic src_match(
    input logic [REG_ADDR_W-1:0] src1,
    input logic [REG_ADDR_W-1:0] src2,
    input logic                  two_src,
    input logic [REG_ADDR_W-1:0] rd
  );
    return (src1 == rd) || (two_src && (src2 == rd));
  endfunction

endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// RAW hazard detection between the ID instruction and those in EX and MEM.
module hazard_detect
  import cpu_ctrl_pkg::*;
(
  input  logic [REG_ADDR_W-1:0] i_id_src1,
  input  logic [REG_ADDR_W-1:0] i_id_src2,
  input  logic                  i_id_two_src,
  input  logic                  i_id_valid,
  input  logic [REG_ADDR_W-1:0] i_ex_rd,
  input  logic                  i_ex_wb_en,
  input  logic                  i_ex_mem_read,
  input  logic [REG_ADDR_W-1:0] i_mem_rd,
  input  logic                  i_mem_wb_en,
  input  logic                  i_fwd_en,
  output logic                  o_hz
);

  logic w_ex_match;
  logic w_mem_match;

  assign w_ex_match  = src_match(i_id_src1, i_id_src2, i_id_two_src, i_ex_rd);
  assign w_mem_match = src_match(i_id_src1, i_id_src2, i_id_two_src, i_mem_rd);

  // With forwarding only a load result in EX is too late to bypass.
  always_comb begin
    o_hz = 1'b0;
    if (i_id_valid) begin
      if (i_fwd_en) begin
        o_hz = w_ex_match && i_ex_mem_read;
      end else begin
        o_hz = (w_ex_match && i_ex_wb_en) || (w_mem_match && i_mem_wb_en);
      end
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: memory wait-state FSM, freeze/branch/hazard priority
// muxing onto the stage registers, and saturating activity counters.
module pipe_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned MEM_WAIT_CYCLES = 2,
  parameter int unsigned CNT_W           = CNT_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [REG_ADDR_W-1:0] id_src1,
  input  logic [REG_ADDR_W-1:0] id_src2,
  input  logic                  id_two_src,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_wb_en,
  input  logic                  ex_mem_read,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  input  logic                  mem_wb_en,
  input  logic                  mem_access,
  input  logic                  branch_taken,
  input  logic                  fwd_en,
  input  logic                  cnt_clr,
  output logic                  freeze_pc,
  output logic                  freeze_if_id,
  output logic                  freeze_id_ex,
  output logic                  freeze_ex_mem,
  output logic                  freeze_mem_wb,
  output logic                  bubble_id_ex,
  output logic                  flush_if_id,
  output logic                  mem_busy,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      freeze_cnt,
  output logic [CNT_W-1:0]      flush_cnt
);

  localparam logic              HAS_WAIT  = (MEM_WAIT_CYCLES != 0);
  localparam logic [WCNT_W-1:0] WAIT_LOAD =
    (MEM_WAIT_CYCLES != 0) ? WCNT_W'(MEM_WAIT_CYCLES - 1) : '0;

  state_e            r_state;
  logic [WCNT_W-1:0] r_wcnt;
  logic [CNT_W-1:0]  r_stall_cnt;
  logic [CNT_W-1:0]  r_freeze_cnt;
  logic [CNT_W-1:0]  r_flush_cnt;

  logic      w_hz;
  logic      w_freeze_all;
  logic      w_flush;
  logic      w_stall;
  pipe_ctl_t w_ctl;

  hazard_detect u_hazard_detect (
    .i_id_src1     (id_src1),
    .i_id_src2     (id_src2),
    .i_id_two_src  (id_two_src),
    .i_id_valid    (id_valid),
    .i_ex_rd       (ex_rd),
    .i_ex_wb_en    (ex_wb_en),
    .i_ex_mem_read (ex_mem_read),
    .i_mem_rd      (mem_rd),
    .i_mem_wb_en   (mem_wb_en),
    .i_fwd_en      (fwd_en),
    .o_hz          (w_hz)
  );

  // The access cycle itself freezes; WAIT keeps freezing until wcnt drains.
  always_comb begin
    w_freeze_all = 1'b0;
    unique case (r_state)
      ST_RUN:  w_freeze_all = HAS_WAIT && mem_access;
      ST_WAIT: w_freeze_all = (r_wcnt != '0);
      default: w_freeze_all = 1'b0;
    endcase
    if (!rst_n) begin
      w_freeze_all = 1'b0;
    end
  end

  // Wait-state FSM; mem_access is not looked at in WAIT so it cannot retrigger.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_RUN;
      r_wcnt  <= '0;
    end else begin
      unique case (r_state)
        ST_RUN: begin
          if (HAS_WAIT && mem_access) begin
            r_state <= ST_WAIT;
            r_wcnt  <= WAIT_LOAD;
          end
        end
        ST_WAIT: begin
          if (r_wcnt != '0) begin
            r_wcnt <= r_wcnt - WCNT_W'(1);
          end else begin
            r_state <= ST_RUN;
          end
        end
        default: begin
          r_state <= ST_RUN;
          r_wcnt  <= '0;
        end
      endcase
    end
  end

  // Priority: freeze_all over branch over hazard.
  assign w_flush = rst_n && branch_taken && !w_freeze_all;
  assign w_stall = rst_n && w_hz && !w_freeze_all && !branch_taken;

  always_comb begin
    w_ctl               = '0;
    w_ctl.freeze_pc     = w_freeze_all || w_stall;
    w_ctl.freeze_if_id  = w_freeze_all || w_stall;
    w_ctl.freeze_id_ex  = w_freeze_all;
    w_ctl.freeze_ex_mem = w_freeze_all;
    w_ctl.freeze_mem_wb = w_freeze_all;
    w_ctl.bubble_id_ex  = w_flush || w_stall;
    w_ctl.flush_if_id   = w_flush;
  end

  assign freeze_pc     = w_ctl.freeze_pc;
  assign freeze_if_id  = w_ctl.freeze_if_id;
  assign freeze_id_ex  = w_ctl.freeze_id_ex;
  assign freeze_ex_mem = w_ctl.freeze_ex_mem;
  assign freeze_mem_wb = w_ctl.freeze_mem_wb;
  assign bubble_id_ex  = w_ctl.bubble_id_ex;
  assign flush_if_id   = w_ctl.flush_if_id;
  assign mem_busy      = rst_n && (r_state == ST_WAIT);

  // Saturating activity counters; clear wins over a same-cycle event.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt  <= '0;
      r_freeze_cnt <= '0;
      r_flush_cnt  <= '0;
    end else if (cnt_clr) begin
      r_stall_cnt  <= '0;
      r_freeze_cnt <= '0;
      r_flush_cnt  <= '0;
    end else begin
      if (w_stall && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
      if (w_freeze_all && (r_freeze_cnt != '1)) begin
        r_freeze_cnt <= r_freeze_cnt + CNT_W'(1);
      end
      if (w_flush && (r_flush_cnt != '1)) begin
        r_flush_cnt <= r_flush_cnt + CNT_W'(1);
      end
    end
  end

  assign stall_cnt  = r_stall_cnt;
  assign freeze_cnt = r_freeze_cnt;
  assign flush_cnt  = r_flush_cnt;

endmodule
